// File: rtl/avg_seq_ctrl.sv
// Running-average sequencer: accumulates NSAMP signed samples, then divides the sum by the divisor latched at start.
// Latency: avg_valid rises ACCW+2 cycles after the last sample handshake, or 1 cycle after it when the divisor is zero.
// Backpressure: smp_ready is high only in ACCUM; avg_valid and avg hold until avg_ready accepts the result.
module avg_seq_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int NSAMP     = 8,
    parameter int ACCW      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] num,
    input  logic                 smp_valid,
    output logic                 smp_ready,
    input  logic [DATAWIDTH-1:0] smp_data,
    output logic [DATAWIDTH-1:0] avg,
    output logic                 avg_valid,
    input  logic                 avg_ready,
    output logic                 busy,
    output logic                 dz_err
);
    localparam int CW = $clog2(NSAMP + 1);
    localparam int BW = $clog2(ACCW + 1);

    typedef enum logic [2:0] {IDLE, ACCUM, DIV, FIX, DONE} state_t;

    state_t               state;
    logic [ACCW-1:0]      acc;
    logic [ACCW-1:0]      dvd;
    logic [DATAWIDTH-1:0] divisor;
    logic [DATAWIDTH-1:0] rem;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitcnt;
    logic                 neg;

    logic [ACCW-1:0]      smp_ext;
    logic [ACCW-1:0]      acc_nxt;
    logic [ACCW-1:0]      acc_abs;
    logic [DATAWIDTH-1:0] dabs;
    logic [DATAWIDTH:0]   trial;
    logic [DATAWIDTH:0]   diff;
    logic                 ge;

    // The remainder stays below |divisor| <= 2^(DATAWIDTH-1), so a DATAWIDTH+1 bit trial never overflows
    // and the sign of trial - |divisor| is the restore decision.
    always_comb begin
        smp_ext = ACCW'($signed(smp_data));
        acc_nxt = acc + smp_ext;
        acc_abs = acc_nxt[ACCW-1] ? -acc_nxt : acc_nxt;
        dabs    = divisor[DATAWIDTH-1] ? -divisor : divisor;
        trial   = {rem, dvd[ACCW-1]};
        diff    = trial - {1'b0, dabs};
        ge      = ~diff[DATAWIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            dvd       <= '0;
            divisor   <= '0;
            rem       <= '0;
            cnt       <= '0;
            bitcnt    <= '0;
            neg       <= 1'b0;
            avg       <= '0;
            avg_valid <= 1'b0;
            smp_ready <= 1'b0;
            busy      <= 1'b0;
            dz_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        divisor   <= num;
                        acc       <= '0;
                        cnt       <= '0;
                        smp_ready <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (smp_valid && smp_ready) begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NSAMP - 1)) begin
                            smp_ready <= 1'b0;
                            if (divisor == '0) begin
                                avg       <= '0;
                                dz_err    <= 1'b1;
                                avg_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                // Quotient bits shift in behind the dividend as it drains out the top.
                                dvd    <= acc_abs;
                                rem    <= '0;
                                bitcnt <= '0;
                                neg    <= acc_nxt[ACCW-1] ^ divisor[DATAWIDTH-1];
                                state  <= DIV;
                            end
                        end
                    end
                end
                DIV: begin
                    dvd    <= {dvd[ACCW-2:0], ge};
                    rem    <= ge ? diff[DATAWIDTH-1:0] : trial[DATAWIDTH-1:0];
                    bitcnt <= bitcnt + BW'(1);
                    if (bitcnt == BW'(ACCW - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    avg       <= neg ? -dvd[DATAWIDTH-1:0] : dvd[DATAWIDTH-1:0];
                    dz_err    <= 1'b0;
                    avg_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (avg_ready) begin
                        avg_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Bench for avg_seq_ctrl: table of operations with expected results queued at start and checked on output handshake.
module tb_avg_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_data;
    logic [15:0] avg;
    logic        avg_valid;
    logic        avg_ready;
    logic        busy;
    logic        dz_err;

    always #5 clk = ~clk;

    avg_seq_ctrl #(.DATAWIDTH(16), .NSAMP(8), .ACCW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num(num),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
        .avg(avg), .avg_valid(avg_valid), .avg_ready(avg_ready),
        .busy(busy), .dz_err(dz_err)
    );

    typedef struct {
        logic [7:0][15:0] s;
        logic [15:0]      num;
        logic [15:0]      avg;
        bit               dz;
        bit               gap;
        int               hold;
    } vec_t;

    localparam int NV = 12;
    vec_t        v[NV];
    logic [16:0] sb[$];
    logic [16:0] mon_e;
    int          checks = 0;
    int          fails  = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7,
                                input int n, input int e, input bit dz, input bit gap, input int hold);
        vec_t r;
        r.s[0] = 16'(a0); r.s[1] = 16'(a1); r.s[2] = 16'(a2); r.s[3] = 16'(a3);
        r.s[4] = 16'(a4); r.s[5] = 16'(a5); r.s[6] = 16'(a6); r.s[7] = 16'(a7);
        r.num  = 16'(n);
        r.avg  = 16'(e);
        r.dz   = dz;
        r.gap  = gap;
        r.hold = hold;
        return r;
    endfunction

    // Scoreboard: every accepted result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && avg_valid && avg_ready) begin
            if (sb.size() == 0) begin
                chk(1'b0, "unexpected_result", $signed(avg), 0);
            end else begin
                mon_e = sb.pop_front();
                chk(avg == mon_e[15:0], "avg", $signed(avg), $signed(mon_e[15:0]));
                chk(dz_err == mon_e[16], "dz_err", int'(dz_err), int'(mon_e[16]));
            end
        end
    end

    task automatic feed(input vec_t t);
        int k = 0;
        int guard = 0;
        bit hs;
        while (k < 8 && guard < 200) begin
            smp_valid = 1'b1;
            smp_data  = t.s[k];
            @(negedge clk);
            if (guard == 0) chk(busy, "busy_after_start", int'(busy), 1);
            hs = smp_valid && smp_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) begin
                k++;
                // Two idle cycles with junk data and a stray start that must both be ignored.
                if (t.gap && k < 8) begin
                    smp_valid = 1'b0;
                    smp_data  = 16'h7FFF;
                    start     = 1'b1;
                    num       = 16'h0;
                    repeat (2) @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        smp_valid = 1'b0;
        if (guard >= 200) chk(1'b0, "feed_timeout", k, 8);
    endtask

    task automatic run_op(input vec_t t);
        int n;
        logic [15:0] held;
        num   = t.num;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num   = ~t.num;
        sb.push_back({t.dz, t.avg});
        feed(t);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (t.gap && n == 5) begin start = 1'b1; num = 16'h0001; end
            if (t.gap && n == 7) start = 1'b0;
        end while (!avg_valid && n < 200);
        start = 1'b0;
        chk(n == (t.dz ? 1 : 34), "latency", n, t.dz ? 1 : 34);
        held = avg;
        for (int i = 0; i < t.hold; i++) begin
            @(negedge clk);
            chk(avg_valid && avg == held, "hold_stable", $signed(avg), $signed(held));
        end
        @(posedge clk); #1;
        avg_ready = 1'b1;
        @(posedge clk); #1;
        avg_ready = 1'b0;
        @(negedge clk);
        chk(!avg_valid && !busy, "idle_after_accept", int'({avg_valid, busy}), 0);
        chk(avg == held, "avg_holds", $signed(avg), $signed(held));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; num = '0; smp_valid = 1'b0; smp_data = '0; avg_ready = 1'b0;

        v[0]  = mk(1, 2, 3, 4, 5, 6, 7, 8,                  8,   4, 0, 0, 0);
        v[1]  = mk(-5, -5, -5, -5, -5, -5, -5, -5,          8,  -5, 0, 0, 0);
        v[2]  = mk(-1, -2, -3, -4, -5, -6, -7, -8,          8,  -4, 0, 0, 0);
        v[3]  = mk(1, 2, 3, 4, 5, 6, 7, 8,                 -8,  -4, 0, 0, 0);
        v[4]  = mk(3, 3, 3, 3, 3, 3, 3, 3,                  0,   0, 1, 0, 0);
        v[5]  = mk(1, 1, 1, 1, 1, 1, 2, 2,                  2,   5, 0, 0, 0);
        v[6]  = mk(1, 2, 3, 4, 5, 6, 7, 8,                  8,   4, 0, 1, 5);
        v[7]  = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 1, -8, 0, 0, 0);
        v[8]  = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 16, 16383, 0, 0, 0);
        v[9]  = mk(7, 7, 7, 7, 7, 7, 7, -7,                -5,  -8, 0, 0, 0);
        v[10] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -1, 0, 0, 0, 0);
        v[11] = mk(100, 200, -50, 0, 0, 0, 0, 0,            7,  35, 0, 1, 2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(avg == 16'h0, "rst_avg", $signed(avg), 0);
        chk(!avg_valid, "rst_avg_valid", int'(avg_valid), 0);
        chk(!smp_ready, "rst_smp_ready", int'(smp_ready), 0);
        chk(!busy, "rst_busy", int'(busy), 0);
        chk(!dz_err, "rst_dz_err", int'(dz_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_op(v[i]);

        // Reset ten cycles into DIV must abort silently; avg_ready stays high to catch any stray result.
        avg_ready = 1'b1;
        num   = 16'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(v[0]);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(avg == 16'h0, "abort_avg", $signed(avg), 0);
        chk(!avg_valid, "abort_avg_valid", int'(avg_valid), 0);
        chk(!smp_ready, "abort_smp_ready", int'(smp_ready), 0);
        chk(!busy, "abort_busy", int'(busy), 0);
        chk(!dz_err, "abort_dz_err", int'(dz_err), 0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (avg_valid || busy) seen = 1'b1;
        end
        chk(!seen, "abort_no_result", int'(seen), 0);
        avg_ready = 1'b0;
        @(posedge clk); #1;

        run_op(v[0]);

        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/avg_seq_ctrl.md
Name: avg_seq_ctrl

Overview:
- Sequencing controller for the running-average datapath: one accumulator and one iterative signed divider, time-multiplexed, replace the unrolled add/register chain plus combinational divide.
- Accepts NSAMP signed samples over a valid/ready stream, accumulates them, divides the sum by a divisor latched at start, and presents the quotient on a valid/ready output.
- Sits between the sample source and the consumer of avg.

Parameters:
- DATAWIDTH, 16: width of samples, divisor and result.
- NSAMP, 8: samples per average. Must be ≥1.
- ACCW, 32: accumulator width and divider iteration count. Must be ≥ DATAWIDTH + clog2(NSAMP).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; sampled only in IDLE.
- num  in  DATAWIDTH  signed divisor; latched on accepted start.
- smp_valid  in  1  sample-stream valid.
- smp_ready  out  1  sample-stream ready.
- smp_data  in  DATAWIDTH  signed sample.
- avg  out  DATAWIDTH  signed quotient.
- avg_valid  out  1  result valid.
- avg_ready  in  1  consumer ready.
- busy  out  1  high in every state except IDLE.
- dz_err  out  1  divide-by-zero flag; qualified by avg_valid.

Behaviour:
- Reset: state=IDLE; avg=0, avg_valid=0, smp_ready=0, busy=0, dz_err=0; accumulator, sample count, divisor and divider registers cleared.
- rst has priority over every other input in every state, including mid-DIV. No partial result is ever emitted after reset.
- IDLE:
  - start=1 latches num, clears accumulator and count, and moves to ACCUM.
  - start=0 stays in IDLE.
- ACCUM:
  - smp_ready=1.
  - A handshake occurs when smp_valid & smp_ready. On each handshake: acc <= acc + sign-extend(smp_data) to ACCW bits, modulo 2^ACCW; count increments.
  - The NSAMP-th handshake moves to DIV, or to DONE if the latched num==0.
  - Cycles with smp_valid=0 change nothing.
- DIV:
  - smp_ready=0.
  - Restoring division on |acc| / |num|, one quotient bit per cycle, MSB first, exactly ACCW cycles, then FIX.
- FIX (1 cycle):
  - Quotient negated if sign(acc) XOR sign(num).
  - Truncates toward zero, matching Verilog signed "/".
  - avg <= low DATAWIDTH bits of the quotient. Higher bits are discarded without saturation.
- DONE:
  - avg_valid=1.
  - On the num==0 path: avg=0 and dz_err=1. Otherwise dz_err=0.
  - On avg_valid & avg_ready: avg_valid<=0 and state moves to IDLE.
  - avg holds its value after the handshake until the next FIX or rst.
- Latency: last sample handshake at cycle T puts avg_valid high at T+ACCW+2 (T+34 at defaults). On the num==0 path, avg_valid is high at T+1.
- start outside IDLE is ignored. start in the same cycle as the DONE handshake is ignored; it must be re-asserted in IDLE.
- Output handshake: avg_valid, once high, stays high and avg stays stable until it is accepted.
- The divisor is num as latched at start. Changes to num after start have no effect.

Test Plan:
- Samples 1..8 back-to-back, num=8 → avg=4 (36/8), dz_err=0, avg_valid at T+34, busy high from the cycle after start until the handshake.
- Eight samples of -5, num=8 → avg=-5 (0xFFFB); then samples summing to -36, num=8 → avg=-4 (truncation toward zero); sum 36 with num=-8 → avg=-4.
- num=0, any 8 samples → avg=0 and dz_err=1 one cycle after the last sample; next operation with num=2 and samples summing to 10 → avg=5, dz_err=0.
- Backpressure: smp_valid toggles 1,0,0,1,... and avg_ready held low for 5 cycles after avg_valid → sum uses exactly 8 accepted samples; avg stable while waiting; start pulsed during ACCUM/DIV is ignored.
- Overflow: eight samples of 32767, num=1 → sum 262136 = 0x3FFF8, avg=0xFFF8 (truncation); with num=16 → avg=16383.
- Reset mid-DIV (rst for 1 cycle, 10 cycles into DIV) → next cycle all outputs at reset values, no avg_valid; a subsequent full operation with samples 1..8, num=8 → avg=4.
